// File: rtl/rvc_compressor_packer.sv
// Streaming RV32 code compactor: re-encodes a subset of base instructions to RVC and packs
// halfwords into 32-bit code words. Define RVC_COMPRESS_EN to enable compression/packing.
module rvc_compressor_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush_req,
    output logic        flush_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [15:0] comp_count
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_word_q, out_word_d;
    logic [15:0] res_q, res_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] comp_count_q, comp_count_d;
    logic        is_c16;
    logic [15:0] c16;

`ifdef RVC_COMPRESS_EN
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm_i, imm_s;
    logic        imm_i_small, rd_c, rs1_c, rs2_c;
    logic        off_i_c, off_i_sp, off_s_c, off_s_sp;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];
    assign imm_i  = in_instr[31:20];
    assign imm_s  = {in_instr[31:25], in_instr[11:7]};

    assign imm_i_small = (imm_i[11:5] == {7{imm_i[5]}});
    assign rd_c        = (rd[4:3] == 2'b01);
    assign rs1_c       = (rs1[4:3] == 2'b01);
    assign rs2_c       = (rs2[4:3] == 2'b01);
    // Word-aligned offsets reachable by the register-relative and sp-relative forms
    assign off_i_c     = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
    assign off_i_sp    = (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'b00);
    assign off_s_c     = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);
    assign off_s_sp    = (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'b00);

    always_comb begin
        is_c16 = 1'b0;
        c16    = 16'h0000;
        case (opcode)
            OpImm: begin
                if (funct3 == 3'b000 && rd != 5'd0 && imm_i_small) begin
                    if (rs1 == 5'd0) begin
                        is_c16 = 1'b1;
                        c16    = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                    end else if (rs1 == rd && imm_i != 12'd0) begin
                        is_c16 = 1'b1;
                        c16    = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                    end
                end else if (funct3 == 3'b001 && funct7 == 7'd0 && rd != 5'd0 && rs1 == rd
                             && rs2 != 5'd0) begin
                    is_c16 = 1'b1;
                    c16    = {4'b0000, rd, rs2, 2'b10};
                end
            end
            OpReg: begin
                if (funct3 == 3'b000 && funct7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0
                    && (rs1 == 5'd0 || rs1 == rd)) begin
                    is_c16 = 1'b1;
                    c16    = {3'b100, rs1 != 5'd0, rd, rs2, 2'b10};
                end else if (rs1 == rd && rd_c && rs2_c) begin
                    if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                        is_c16 = 1'b1;
                        c16    = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
                    end else if (funct7 == 7'd0 && (funct3 == 3'b100 || funct3[2:1] == 2'b11)) begin
                        // xor/or/and (100/110/111) map to sub-op 01/10/11
                        is_c16 = 1'b1;
                        c16    = {6'b100011, rd[2:0], funct3[1], funct3[0] | ~funct3[1],
                                  rs2[2:0], 2'b01};
                    end
                end
            end
            OpJalr: begin
                if (funct3 == 3'b000 && rd == 5'd0 && imm_i == 12'd0 && rs1 != 5'd0) begin
                    is_c16 = 1'b1;
                    c16    = {4'b1000, rs1, 5'd0, 2'b10};
                end
            end
            OpLoad: begin
                if (funct3 == 3'b010 && rd_c && rs1_c && off_i_c) begin
                    is_c16 = 1'b1;
                    c16    = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                end else if (funct3 == 3'b010 && rs1 == 5'd2 && rd != 5'd0 && off_i_sp) begin
                    is_c16 = 1'b1;
                    c16    = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
                end
            end
            OpStore: begin
                if (funct3 == 3'b010 && rs1_c && rs2_c && off_s_c) begin
                    is_c16 = 1'b1;
                    c16    = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                end else if (funct3 == 3'b010 && rs1 == 5'd2 && off_s_sp) begin
                    is_c16 = 1'b1;
                    c16    = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
                end
            end
            default: begin
                is_c16 = 1'b0;
            end
        endcase
    end
`else
    assign is_c16 = 1'b0;
    assign c16    = 16'h0000;
`endif

    assign in_ready   = !out_valid_q || out_ready;
    assign flush_ack  = flush_req && !res_valid_q && !out_valid_q;
    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign comp_count = comp_count_q;

    always_comb begin
        out_valid_d  = out_valid_q && !out_ready;
        out_word_d   = out_word_q;
        res_d        = res_q;
        res_valid_d  = res_valid_q;
        comp_count_d = comp_count_q;
        if (in_valid && in_ready) begin
            if (is_c16) begin
                if (comp_count_q != 16'hFFFF) begin
                    comp_count_d = comp_count_q + 16'd1;
                end
                if (res_valid_q) begin
                    out_valid_d = 1'b1;
                    out_word_d  = {c16, res_q};
                    res_valid_d = 1'b0;
                end else begin
                    res_d       = c16;
                    res_valid_d = 1'b1;
                end
            end else if (res_valid_q) begin
                // Misaligned 32-bit: low half completes this word, high half becomes residue
                out_valid_d = 1'b1;
                out_word_d  = {in_instr[15:0], res_q};
                res_d       = in_instr[31:16];
            end else begin
                out_valid_d = 1'b1;
                out_word_d  = in_instr;
            end
        end else if (flush_req && !in_valid && res_valid_q && in_ready) begin
            out_valid_d = 1'b1;
            out_word_d  = {16'h0001, res_q};
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= 32'h0000_0000;
            res_q        <= 16'h0000;
            res_valid_q  <= 1'b0;
            comp_count_q <= 16'h0000;
        end else begin
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            comp_count_q <= comp_count_d;
        end
    end

endmodule

// File: tb/tb_rvc_compressor_packer.sv
// Self-checking bench for rvc_compressor_packer: halfword-queue reference model checked every
// cycle, randomized stimulus, plus directed cases with hand-computed code words.
module tb_rvc_compressor_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush_req;
    logic        flush_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [15:0] comp_count;

    int checks = 0;
    int errors = 0;
    int acks   = 0;

    // Reference model state
    logic [15:0] hq[$];
    logic        m_ov    = 1'b0;
    logic [31:0] m_word  = 32'h0;
    logic [15:0] m_cc    = 16'h0;
    bit          m_armed = 1'b0;
    logic [31:0] got[$];

    always #5 clk = ~clk;

    rvc_compressor_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .comp_count (comp_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input string name, input int idx, input logic [31:0] exp);
        checks++;
        if (idx >= got.size()) begin
            errors++;
            $display("FAIL %s: word %0d missing, expected %h", name, idx, exp);
        end else if (got[idx] !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got[idx], exp);
        end
    endtask

    function automatic bit creg(input logic [4:0] r);
        return (r >= 5'd8) && (r <= 5'd15);
    endfunction

    // RVC encoding of one instruction straight from the subset rules; 0 means no compression
    function automatic bit model_compress(input logic [31:0] i, output logic [15:0] c);
`ifdef RVC_COMPRESS_EN
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic [5:0] i6;
        logic [7:0] u;
        int imm, simm;
        op   = i[6:0];
        rd   = i[11:7];
        f3   = i[14:12];
        rs1  = i[19:15];
        rs2  = i[24:20];
        f7   = i[31:25];
        imm  = int'($signed(i[31:20]));
        simm = int'($signed({i[31:25], i[11:7]}));
        i6   = imm[5:0];
        c    = 16'h0;
        if (op == 7'h13 && f3 == 3'd0 && rd != 5'd0 && imm >= -32 && imm <= 31) begin
            if (rs1 == 5'd0) begin
                c = {3'b010, i6[5], rd, i6[4:0], 2'b01};
                return 1'b1;
            end
            if (rs1 == rd && imm != 0) begin
                c = {3'b000, i6[5], rd, i6[4:0], 2'b01};
                return 1'b1;
            end
        end
        if (op == 7'h13 && f3 == 3'd1 && f7 == 7'd0 && rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
            c = {4'b0000, rd, rs2, 2'b10};
            return 1'b1;
        end
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
            if (rs1 == 5'd0) begin
                c = {4'b1000, rd, rs2, 2'b10};
                return 1'b1;
            end
            if (rs1 == rd) begin
                c = {4'b1001, rd, rs2, 2'b10};
                return 1'b1;
            end
        end
        if (op == 7'h33 && rs1 == rd && creg(rd) && creg(rs2)) begin
            if (f7 == 7'h20 && f3 == 3'd0) begin
                c = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
                return 1'b1;
            end
            if (f7 == 7'd0 && f3 == 3'd4) begin
                c = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
                return 1'b1;
            end
            if (f7 == 7'd0 && f3 == 3'd6) begin
                c = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
                return 1'b1;
            end
            if (f7 == 7'd0 && f3 == 3'd7) begin
                c = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
                return 1'b1;
            end
        end
        if (op == 7'h67 && f3 == 3'd0 && rd == 5'd0 && imm == 0 && rs1 != 5'd0) begin
            c = {4'b1000, rs1, 5'd0, 2'b10};
            return 1'b1;
        end
        if (op == 7'h03 && f3 == 3'd2 && imm >= 0 && imm % 4 == 0) begin
            u = imm[7:0];
            if (creg(rd) && creg(rs1) && imm <= 124) begin
                c = {3'b010, u[5:3], rs1[2:0], u[2], u[6], rd[2:0], 2'b00};
                return 1'b1;
            end
            if (rs1 == 5'd2 && rd != 5'd0 && imm <= 252) begin
                c = {3'b010, u[5], rd, u[4:2], u[7:6], 2'b10};
                return 1'b1;
            end
        end
        if (op == 7'h23 && f3 == 3'd2 && simm >= 0 && simm % 4 == 0) begin
            u = simm[7:0];
            if (creg(rs1) && creg(rs2) && simm <= 124) begin
                c = {3'b110, u[5:3], rs1[2:0], u[2], u[6], rs2[2:0], 2'b00};
                return 1'b1;
            end
            if (rs1 == 5'd2 && simm <= 252) begin
                c = {3'b110, u[5:2], u[7:6], rs2, 2'b10};
                return 1'b1;
            end
        end
        return 1'b0;
`else
        c = i[15:0] & 16'h0;
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        logic [15:0] c;
        if (m_armed) begin
            check("in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) check("out_word", out_word, m_word);
            check("comp_count", 32'(comp_count), 32'(m_cc));
            check("flush_ack", 32'(flush_ack), 32'(flush_req && hq.size() == 0 && !m_ov));
            if (out_valid && out_ready && reset_n) got.push_back(out_word);
            if (flush_ack && reset_n) acks++;
        end
        if (!reset_n) begin
            hq.delete();
            m_ov    = 1'b0;
            m_word  = 32'h0;
            m_cc    = 16'h0;
            m_armed = 1'b1;
        end else if (m_armed) begin
            if (in_valid && (!m_ov || out_ready)) begin
                if (model_compress(in_instr, c)) begin
                    hq.push_back(c);
                    if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
                end else begin
                    hq.push_back(in_instr[15:0]);
                    hq.push_back(in_instr[31:16]);
                end
            end else if (flush_req && !in_valid && hq.size() == 1 && (!m_ov || out_ready)) begin
                hq.push_back(16'h0001);
            end
            if (hq.size() >= 2) begin
                m_word = {hq[1], hq[0]};
                void'(hq.pop_front());
                void'(hq.pop_front());
                m_ov = 1'b1;
            end else begin
                m_ov = m_ov && !out_ready;
            end
        end
    end

    task automatic send(input logic [31:0] instr);
        int n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send: in_ready stuck 0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input string name);
        int n = 0;
        acks = 0;
        flush_req = 1'b1;
        while (acks == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        flush_req = 1'b0;
        check(name, 32'(acks > 0), 32'd1);
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 1) == 1) return 5'(8 + $urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [11:0] rimm();
        int v;
        if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 63)) - 32;
        else v = int'($urandom_range(0, 4095)) - 2048;
        return v[11:0];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic [31:0] r;
        int k;
        rd  = rreg();
        rs2 = rreg();
        k   = int'($urandom_range(0, 2));
        rs1 = (k == 0) ? rd : (k == 1) ? 5'd0 : rreg();
        imm = rimm();
        r   = $urandom();
        f3  = 3'b000;
        f7  = 7'd0;
        case ($urandom_range(0, 7))
            0: return {imm, rs1, 3'b000, rd, 7'h13};
            1: return {7'd0, rs2, rs1, 3'b001, rd, 7'h13};
            2: begin
                case ($urandom_range(0, 4))
                    1: f7 = 7'h20;
                    2: f3 = 3'b100;
                    3: f3 = 3'b110;
                    4: f3 = 3'b111;
                    default: f3 = 3'b000;
                endcase
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            3: begin
                if ($urandom_range(0, 3) != 0) imm = 12'd0;
                if ($urandom_range(0, 3) != 0) rd = 5'd0;
                return {imm, rs1, 3'b000, rd, 7'h67};
            end
            4, 5: begin
                if ($urandom_range(0, 2) != 0) imm = 12'(4 * $urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) rs1 = 5'd2;
                if (k == 0) return {imm, rs1, 3'b010, rd, 7'h03};
                return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            end
            6: begin
                case ($urandom_range(0, 3))
                    0: op = 7'h37;
                    1: op = 7'h17;
                    2: op = 7'h6F;
                    default: op = 7'h63;
                endcase
                return {r[31:7], op};
            end
            default: return {r[31:2], 2'b11};
        endcase
        return {r[31:2], 2'b11};
    endfunction

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush_req = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_word", out_word, 32'h0);
        check("reset comp_count", 32'(comp_count), 32'd0);
        check("reset flush_ack", 32'(flush_ack), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Two addi x8,x8,1
        got.delete();
        send(32'h00140413);
        send(32'h00140413);
        idle(3);
`ifdef RVC_COMPRESS_EN
        check("pair words", 32'(got.size()), 32'd1);
        expect_word("pair word", 0, 32'h04050405);
        check("pair comp_count", 32'(comp_count), 32'd2);
`else
        check("pair words", 32'(got.size()), 32'd2);
        expect_word("pair word0", 0, 32'h00140413);
        expect_word("pair word1", 1, 32'h00140413);
        check("pair comp_count", 32'(comp_count), 32'd0);
`endif

        // addi then lui, then flush the residue
        got.delete();
        send(32'h00140413);
        send(32'h123452B7);
        idle(3);
        do_flush("flush ack");
        idle(3);
`ifdef RVC_COMPRESS_EN
        expect_word("misaligned lui", 0, 32'h52B70405);
        expect_word("flush pad", 1, 32'h00011234);
        check("flush words", 32'(got.size()), 32'd2);
`else
        expect_word("addi pass", 0, 32'h00140413);
        expect_word("lui pass", 1, 32'h123452B7);
        check("flush words", 32'(got.size()), 32'd2);
`endif

        // lw x9,8(x10) then add x10,x0,x11
        got.delete();
        send(32'h00852483);
        send(32'h00B00533);
        idle(3);
`ifdef RVC_COMPRESS_EN
        expect_word("c.lw+c.mv", 0, 32'h852E4504);
`else
        expect_word("lw pass", 0, 32'h00852483);
        expect_word("add pass", 1, 32'h00B00533);
`endif

        // Out-of-range immediates stay 32-bit
        got.delete();
        send(32'h02040413);
        send(32'h08052483);
        idle(3);
        expect_word("addi imm32", 0, 32'h02040413);
        expect_word("lw off128", 1, 32'h08052483);
`ifdef RVC_COMPRESS_EN
        check("range comp_count", 32'(comp_count), 32'd5);
`else
        check("range comp_count", 32'(comp_count), 32'd0);
`endif

        // Backpressure during a 32-bit stream
        got.delete();
        out_ready = 1'b0;
        send(32'h000010B7);
        in_valid = 1'b1;
        in_instr = 32'h000020B7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_word", out_word, 32'h000010B7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h000020B7);
        send(32'h000030B7);
        idle(3);
        check("bp words", 32'(got.size()), 32'd3);
        expect_word("bp w0", 0, 32'h000010B7);
        expect_word("bp w1", 1, 32'h000020B7);
        expect_word("bp w2", 2, 32'h000030B7);

        // Reset with residue pending
        send(32'h00140413);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_word", out_word, 32'h0);
        check("rst comp_count", 32'(comp_count), 32'd0);
        reset_n = 1'b1;
        got.delete();
        send(32'h123452B7);
        idle(3);
        check("rst words", 32'(got.size()), 32'd1);
        expect_word("rst unshifted", 0, 32'h123452B7);

        // Randomized traffic against the model
        for (int n = 0; n < 6000; n++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 7) == 0);
            reset_n   = ($urandom_range(0, 799) != 0);
        end
        in_valid  = 1'b0;
        flush_req = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b1;
        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
